serial_conv_window: RTL and testbench
=====================================

Name: serial_conv_window

Overview:
- Datapath stage directly downstream of the serial-mode sequencer.
- Per stride, the sequencer raises `en` and presents `feature_baseaddr`. This block then:
  - reads a 3x3 feature window and the 9 kernel weights from synchronous memories,
  - multiply-accumulates them serially,
  - returns a single-cycle `is_done` pulse that the sequencer consumes to advance to the next stride.
- One window per start; the result is held until the next window completes.

Parameters:
- `DATA_W`, 8, signed feature/weight width
- `ACC_W`, 20, signed accumulator/result width (holds 9 full-scale products, 2*`DATA_W`+4)
- `ADDR_W`, 8, feature/weight address width
- `IMG_W`, 4, feature-map row pitch in words
- `BASE_OFS`, 9, subtracted from `feature_baseaddr` to form the window origin (9,10,13,14 map to origins 0,1,4,5)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  window request level from sequencer
- `feature_baseaddr`  in  `ADDR_W`  window tag from sequencer
- `feat_rd_en`  out  1  feature memory read strobe
- `feat_addr`  out  `ADDR_W`  feature memory address
- `feat_rdata`  in  `DATA_W`  feature read data, valid 1 cycle after strobe
- `wgt_rd_en`  out  1  weight memory read strobe
- `wgt_addr`  out  `ADDR_W`  weight memory address (0..8)
- `wgt_rdata`  in  `DATA_W`  weight read data, valid 1 cycle after strobe
- `result`  out  `ACC_W`  signed window sum, held
- `result_valid`  out  1  1-cycle pulse, new result
- `is_done`  out  1  1-cycle pulse to sequencer `is_done_i`

Behaviour:
- **Reset** (`rst`=0, async): state IDLE. All of the following clear to 0:
  - registered outputs: `result`, `result_valid`, `is_done`, `feat_rd_en`, `wgt_rd_en`, `feat_addr`, `wgt_addr`
  - internal state: `acc`, `k`, `last_tag`, `en_q`, `tag_valid`
- **States:** IDLE, READ, DRAIN, DONE.
- **Start rule:** in IDLE, start when `en`=1 AND (`en_q`=0 OR `tag_valid`=0 OR `feature_baseaddr`!=`last_tag`).
  - `en_q` is `en` delayed by one cycle.
  - This suppresses a repeat window when the sequencer holds `en` high with an unchanged address after its last stride.
- **On start:**
  - latch `origin` = `feature_baseaddr` - `BASE_OFS` (mod 2^`ADDR_W`).
  - `last_tag` <= `feature_baseaddr`; `tag_valid` <= 1; `acc` <= 0; `k` <= 0; go to READ.
- **READ** (9 cycles, k=0..8):
  - drive `feat_rd_en`=`wgt_rd_en`=1.
  - `feat_addr` = `origin` + (k/3)*`IMG_W` + (k%3), `wgt_addr` = k. All address arithmetic is mod 2^`ADDR_W` with no range check.
  - the data-valid flag is the read strobe delayed 1 cycle; when set, `acc` += sext(`feat_rdata`) * sext(`wgt_rdata`).
  - at k=8 go to DRAIN.
- **DRAIN** (1 cycle): strobes 0; final product accumulated.
- **DONE** (1 cycle): `result` <= `acc`; `result_valid`=1; `is_done`=1; then IDLE.
- **Latency:** start-detect cycle = C0. Reads issue C1..C9, DRAIN C10, `is_done`/`result_valid` high in C11. Next start is possible no earlier than C12.
- **Abort:** if `en`=0 during READ or DRAIN:
  - go to IDLE next edge, drop strobes, clear `acc`, clear `tag_valid`.
  - no `is_done`; `result` unchanged.
- `en` in DONE is ignored.
- **Overflow:** none possible at defaults. No saturation logic.
- `feature_baseaddr` changes after start are ignored (origin latched).

Decomposition:
- Shared package:
  - state encoding (IDLE/READ/DRAIN/DONE)
  - `IMG_W`, `BASE_OFS`, `KERNEL_TAPS`=9
  - the stride address constants 9,10,13,14, shared with the sequencer.
- One sub-module: `serial_mac` (signed `DATA_W`x`DATA_W` multiply, `ACC_W` accumulate, with `clear` and `valid` inputs).

Test Plan:
- features 1..16 at addrs 9..24 (tag-relative), weights all 1, `en`=1, tag 9 -> `is_done` exactly in C11, `result`=sum of origin-0 window.
- weights {1,0,-1,2,0,-2,1,0,-1}, features all 127, tag 10 -> `result`=0; then features = address value -> matching hand-computed sum.
- all features -128, all weights -128 -> `result`=147456, no wrap in 20 bits.
- sequencer model runs tags 9,10,13,14 holding `en`=1 throughout and one extra cycle after the last stride -> exactly 4 `is_done` pulses, results for origins 0,1,4,5.
- `en` dropped at C5 -> no `is_done`, `result` keeps prior value; restart with same tag -> full window computed.
- `rst` asserted at C6 mid-READ -> all outputs 0 immediately, state IDLE; release with `en`=1 -> fresh window, correct result.

Source files
------------

// File: rtl/serial_conv_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_conv_window_pkg
// Description : Shared state encoding, window geometry and stride tags for
//               the serial convolution window stage and its sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_conv_window_pkg;

    // Window engine states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Feature-map row pitch in words
    localparam int IMG_W       = 4;
    // Offset between the sequencer's window tag and the window origin
    localparam int BASE_OFS    = 9;
    // 3x3 kernel
    localparam int KERNEL_TAPS = 9;

    // Window tags the sequencer walks through, one per stride
    localparam int         NUM_STRIDES = 4;
    localparam logic [7:0] STRIDE_ADDR [NUM_STRIDES] = '{8'd9, 8'd10, 8'd13, 8'd14};

    // Address offset of tap k (row-major in the 3x3 window) from the origin
    function automatic int tap_offset(input logic [3:0] k, input int img_w);
        int row;
        int col;
        if (k >= 4'd6) begin
            row = 2;
        end else if (k >= 4'd3) begin
            row = 1;
        end else begin
            row = 0;
        end
        col = int'(k) - 3 * row;
        return row * img_w + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_conv_window_mac.sv
`default_nettype none
// ============================================================================
// Module      : serial_mac
// Description : Serial signed multiply-accumulate. Exposes the next
//               accumulator value so the caller can capture the sum in the
//               same edge that folds in the final product.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mac
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc_next
);
    import serial_conv_window_pkg::*;

    logic signed [2*DATA_W-1:0] prod;
    logic        [ACC_W-1:0]    acc_q;
    logic        [ACC_W-1:0]    acc_d;

    // Next accumulator: clear wins over a pending product
    always_comb begin
        prod  = $signed(a) * $signed(b);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (valid) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

    assign acc_next = acc_d;

    // Accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_conv_window.sv
`default_nettype none
// ============================================================================
// Module      : serial_conv_window
// Description : Reads one 3x3 feature window plus kernel weights from
//               synchronous memories, accumulates serially and pulses
//               is_done back to the stride sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_conv_window
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int ADDR_W   = 8,
    parameter int IMG_W    = serial_conv_window_pkg::IMG_W,
    parameter int BASE_OFS = serial_conv_window_pkg::BASE_OFS
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] feature_baseaddr,
    output logic              feat_rd_en,
    output logic [ADDR_W-1:0] feat_addr,
    input  logic [DATA_W-1:0] feat_rdata,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic [DATA_W-1:0] wgt_rdata,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              is_done
);
    import serial_conv_window_pkg::*;

    state_t            state_q,        state_d;
    logic [3:0]        k_q,            k_d;
    logic [ADDR_W-1:0] origin_q,       origin_d;
    logic [ADDR_W-1:0] last_tag_q,     last_tag_d;
    logic              tag_valid_q,    tag_valid_d;
    logic              en_q;
    logic              feat_rd_en_q,   feat_rd_en_d;
    logic              wgt_rd_en_q,    wgt_rd_en_d;
    logic [ADDR_W-1:0] feat_addr_q,    feat_addr_d;
    logic [ADDR_W-1:0] wgt_addr_q,     wgt_addr_d;
    logic              rvalid_q;
    logic [ACC_W-1:0]  result_q,       result_d;
    logic              result_valid_q, result_valid_d;
    logic              is_done_q,      is_done_d;

    logic              start;
    logic [3:0]        k_next;
    logic              mac_clear;
    logic              mac_valid;
    logic [ACC_W-1:0]  mac_acc_next;

    // A held en with an unchanged tag is the sequencer idling after its last
    // stride, not a new request
    assign start  = en && (!en_q || !tag_valid_q || (feature_baseaddr != last_tag_q));
    assign k_next = k_q + 4'd1;

    // Read data lags the strobe by one cycle; only in-window data counts
    assign mac_valid = rvalid_q && ((state_q == ST_READ) || (state_q == ST_DRAIN));

    // Next-state and registered-output decode
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        origin_d       = origin_q;
        last_tag_d     = last_tag_q;
        tag_valid_d    = tag_valid_q;
        feat_rd_en_d   = 1'b0;
        wgt_rd_en_d    = 1'b0;
        feat_addr_d    = feat_addr_q;
        wgt_addr_d     = wgt_addr_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        is_done_d      = 1'b0;
        mac_clear      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    origin_d     = feature_baseaddr - ADDR_W'(BASE_OFS);
                    last_tag_d   = feature_baseaddr;
                    tag_valid_d  = 1'b1;
                    mac_clear    = 1'b1;
                    k_d          = 4'd0;
                    feat_addr_d  = origin_d;
                    wgt_addr_d   = '0;
                    feat_rd_en_d = 1'b1;
                    wgt_rd_en_d  = 1'b1;
                    state_d      = ST_READ;
                end
            end
            ST_READ: begin
                if (!en) begin
                    mac_clear   = 1'b1;
                    tag_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (k_q == 4'(KERNEL_TAPS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d          = k_next;
                    feat_addr_d  = origin_q + ADDR_W'(tap_offset(k_next, IMG_W));
                    wgt_addr_d   = ADDR_W'(k_next);
                    feat_rd_en_d = 1'b1;
                    wgt_rd_en_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!en) begin
                    mac_clear   = 1'b1;
                    tag_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    // Capture includes the product being folded in this edge
                    result_d       = mac_acc_next;
                    result_valid_d = 1'b1;
                    is_done_d      = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            k_q            <= '0;
            origin_q       <= '0;
            last_tag_q     <= '0;
            tag_valid_q    <= 1'b0;
            en_q           <= 1'b0;
            feat_rd_en_q   <= 1'b0;
            wgt_rd_en_q    <= 1'b0;
            feat_addr_q    <= '0;
            wgt_addr_q     <= '0;
            rvalid_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            is_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            origin_q       <= origin_d;
            last_tag_q     <= last_tag_d;
            tag_valid_q    <= tag_valid_d;
            en_q           <= en;
            feat_rd_en_q   <= feat_rd_en_d;
            wgt_rd_en_q    <= wgt_rd_en_d;
            feat_addr_q    <= feat_addr_d;
            wgt_addr_q     <= wgt_addr_d;
            rvalid_q       <= feat_rd_en_q;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            is_done_q      <= is_done_d;
        end
    end

    serial_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clear    (mac_clear),
        .valid    (mac_valid),
        .a        (feat_rdata),
        .b        (wgt_rdata),
        .acc_next (mac_acc_next)
    );

    assign feat_rd_en   = feat_rd_en_q;
    assign wgt_rd_en    = wgt_rd_en_q;
    assign feat_addr    = feat_addr_q;
    assign wgt_addr     = wgt_addr_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign is_done      = is_done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_conv_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_conv_window
// Description : Self-checking bench for serial_conv_window with synchronous
//               memory models and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_conv_window;
    import serial_conv_window_pkg::*;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [ADDR_W-1:0] feature_baseaddr;
    logic              feat_rd_en;
    logic [ADDR_W-1:0] feat_addr;
    logic [DATA_W-1:0] feat_rdata;
    logic              wgt_rd_en;
    logic [ADDR_W-1:0] wgt_addr;
    logic [DATA_W-1:0] wgt_rdata;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              is_done;

    logic signed [DATA_W-1:0] feat_mem [256];
    logic signed [DATA_W-1:0] wgt_mem  [256];

    logic signed [ACC_W-1:0] sb_q [$];
    logic signed [ACC_W-1:0] last_exp = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_conv_window u_dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .feature_baseaddr (feature_baseaddr),
        .feat_rd_en       (feat_rd_en),
        .feat_addr        (feat_addr),
        .feat_rdata       (feat_rdata),
        .wgt_rd_en        (wgt_rd_en),
        .wgt_addr         (wgt_addr),
        .wgt_rdata        (wgt_rdata),
        .result           (result),
        .result_valid     (result_valid),
        .is_done          (is_done)
    );

    // Synchronous read memories: data one cycle after the strobe
    always @(posedge clk) begin
        if (feat_rd_en) feat_rdata <= feat_mem[feat_addr];
        if (wgt_rd_en)  wgt_rdata  <= wgt_mem[wgt_addr];
    end

    // Reference window sum computed from the memory contents
    function automatic logic signed [ACC_W-1:0] model(input logic [7:0] tag);
        logic [7:0] org;
        logic [7:0] a;
        int sum;
        sum = 0;
        org = tag - 8'(BASE_OFS);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                a   = org + 8'(r * IMG_W + c);
                sum = sum + int'(feat_mem[a]) * int'(wgt_mem[r * 3 + c]);
            end
        end
        return ACC_W'(sum);
    endfunction

    // Scoreboard: every new result must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && result_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: result_valid with result %0d, none expected", $signed(result));
            end else begin
                last_exp = sb_q.pop_front();
                if (result !== last_exp) begin
                    errors++;
                    $display("FAIL sb_result: got %0d expected %0d", $signed(result), last_exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Returns the index of the negedge (1 = first after start edge) carrying is_done, -1 on timeout
    task automatic wait_done(input int max, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < max) begin
            i++;
            @(negedge clk);
            if (is_done === 1'b1) n = i;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        feature_baseaddr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({result, result_valid, is_done, feat_rd_en, wgt_rd_en, feat_addr, wgt_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {result, result_valid, is_done, feat_rd_en, wgt_rd_en, feat_addr, wgt_addr});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int strobes;
        int dones;
        int done_at;
        logic [7:0] exp_addr;
        for (int a = 0; a < 256; a++) begin
            feat_mem[a] = (a < 16) ? 8'(a + 1) : 8'd0;
            wgt_mem[a]  = 8'd1;
        end
        strobes = 0;
        dones   = 0;
        done_at = -1;
        feature_baseaddr = STRIDE_ADDR[0];
        en = 1'b1;
        sb_q.push_back(model(STRIDE_ADDR[0]));
        @(posedge clk);
        // en held high with the same tag for the whole loop: only one window
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (feat_rd_en === 1'b1) begin
                exp_addr = 8'((strobes / 3) * IMG_W + (strobes % 3));
                checks++;
                if (feat_addr !== exp_addr || wgt_addr !== 8'(strobes) || wgt_rd_en !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_addr: tap %0d got feat %0d wgt %0d expected feat %0d wgt %0d",
                             strobes, feat_addr, wgt_addr, exp_addr, strobes);
                end
                strobes++;
            end
            if (is_done === 1'b1) begin
                dones++;
                if (done_at < 0) done_at = n;
                checks++;
                if (result_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_valid_align: result_valid got %b expected 1", result_valid);
                end
            end
        end
        checks++;
        if (done_at != 11) begin
            errors++;
            $display("FAIL basic_latency: is_done in cycle %0d expected 11", done_at);
        end
        checks++;
        if (strobes != 9) begin
            errors++;
            $display("FAIL basic_strobes: got %0d read cycles expected 9", strobes);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL basic_suppress: got %0d is_done pulses expected 1", dones);
        end
        checks++;
        if ($signed(result) !== 54) begin
            errors++;
            $display("FAIL basic_result_hold: got %0d expected 54", $signed(result));
        end
        idle(3);
    endtask

    task automatic test_weights();
        int n;
        logic signed [7:0] w [9];
        w = '{8'sd1, 8'sd0, -8'sd1, 8'sd2, 8'sd0, -8'sd2, 8'sd1, 8'sd0, -8'sd1};
        for (int a = 0; a < 256; a++) begin
            feat_mem[a] = 8'sd127;
            wgt_mem[a]  = (a < 9) ? w[a] : 8'sd0;
        end
        feature_baseaddr = STRIDE_ADDR[1];
        en = 1'b1;
        sb_q.push_back(model(STRIDE_ADDR[1]));
        @(posedge clk);
        wait_done(30, n);
        checks++;
        if (n != 11 || $signed(result) !== 0) begin
            errors++;
            $display("FAIL weights_flat: done cycle %0d result %0d expected cycle 11 result 0", n, $signed(result));
        end
        idle(3);
        for (int a = 0; a < 256; a++) feat_mem[a] = 8'(a);
        en = 1'b1;
        sb_q.push_back(model(STRIDE_ADDR[1]));
        @(posedge clk);
        wait_done(30, n);
        checks++;
        if (n != 11 || $signed(result) !== -8) begin
            errors++;
            $display("FAIL weights_ramp: done cycle %0d result %0d expected cycle 11 result -8", n, $signed(result));
        end
        idle(3);
    endtask

    task automatic test_extreme();
        int n;
        for (int a = 0; a < 256; a++) begin
            feat_mem[a] = -8'sd128;
            wgt_mem[a]  = -8'sd128;
        end
        feature_baseaddr = STRIDE_ADDR[0];
        en = 1'b1;
        sb_q.push_back(model(STRIDE_ADDR[0]));
        @(posedge clk);
        wait_done(30, n);
        checks++;
        if (n != 11 || result !== 20'd147456) begin
            errors++;
            $display("FAIL extreme_sum: done cycle %0d result %0d expected cycle 11 result 147456", n, result);
        end
        idle(3);
    endtask

    task automatic test_sequencer();
        int idx;
        int dones;
        int c;
        logic signed [7:0] w [9];
        w = '{8'sd3, -8'sd1, 8'sd2, 8'sd0, 8'sd1, -8'sd2, -8'sd3, 8'sd1, 8'sd2};
        for (int a = 0; a < 256; a++) begin
            feat_mem[a] = 8'(a * 5 - 40);
            wgt_mem[a]  = (a < 9) ? w[a] : 8'sd0;
        end
        for (int i = 0; i < NUM_STRIDES; i++) sb_q.push_back(model(STRIDE_ADDR[i]));
        idx   = 0;
        dones = 0;
        c     = 0;
        feature_baseaddr = STRIDE_ADDR[0];
        en = 1'b1;
        // Sequencer advances the tag on each is_done and keeps en high
        while (idx < NUM_STRIDES && c < 200) begin
            c++;
            @(negedge clk);
            if (is_done === 1'b1) begin
                dones++;
                idx++;
                if (idx < NUM_STRIDES) feature_baseaddr = STRIDE_ADDR[idx];
            end
        end
        repeat (20) begin
            @(negedge clk);
            if (is_done === 1'b1) dones++;
        end
        checks++;
        if (dones != NUM_STRIDES) begin
            errors++;
            $display("FAIL seq_pulses: got %0d is_done pulses expected %0d", dones, NUM_STRIDES);
        end
        idle(3);
    endtask

    task automatic test_abort();
        int n;
        int dones;
        logic [ACC_W-1:0] held;
        held  = last_exp;
        dones = 0;
        feature_baseaddr = STRIDE_ADDR[2];
        en = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (is_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || feat_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: pulses %0d strobe %b expected 0 and 0", dones, feat_rd_en);
        end
        checks++;
        if (result !== held) begin
            errors++;
            $display("FAIL abort_hold: got %0d expected %0d", $signed(result), $signed(held));
        end
        en = 1'b1;
        sb_q.push_back(model(STRIDE_ADDR[2]));
        @(posedge clk);
        wait_done(30, n);
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL abort_restart: done cycle %0d expected 11", n);
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        int n;
        feature_baseaddr = STRIDE_ADDR[3];
        en = 1'b1;
        @(posedge clk);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({result, result_valid, is_done, feat_rd_en, wgt_rd_en, feat_addr, wgt_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {result, result_valid, is_done, feat_rd_en, wgt_rd_en, feat_addr, wgt_addr});
        end
        @(negedge clk);
        checks++;
        if (feat_rd_en !== 1'b0 || is_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: strobe %b done %b expected 0 0", feat_rd_en, is_done);
        end
        rst = 1'b1;
        sb_q.push_back(model(STRIDE_ADDR[3]));
        @(posedge clk);
        wait_done(30, n);
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL reset_mid_restart: done cycle %0d expected 11", n);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_weights();
        test_extreme();
        test_sequencer();
        test_abort();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d results never produced, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
